muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Execute-stage controller for the RV32M extension: multi-cycle MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Accepts an M-op from the E stage, latches its operands and sequences a fixed-latency multiplier or a 32-iteration restoring divider.
- Raises `muldiv_stall_e` toward the hazard logic (stalls F/D/E, bubbles M) until the result is ready.
- Presents the result for exactly one cycle so the instruction can advance.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- MUL_LAT, 2, cycles spent in MUL state (1..4).
- DIV_ITERS, 32, restoring-divide iterations (must equal XLEN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- md_valid_e  in  1  M-op present in Execute (held while stalled)
- md_funct3_e  in  3  RV32M funct3
- src_a_e  in  XLEN  forwarded rs1 value
- src_b_e  in  XLEN  forwarded rs2 value
- kill_e  in  1  squash the current E instruction (trap/redirect)
- muldiv_stall_e  out  1  hold F/D/E, bubble M
- md_result_e  out  XLEN  result, valid when md_done_e
- md_done_e  out  1  result valid this cycle
- md_busy  out  1  state != IDLE (debug/perf)

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-high, port `reset`.
- Reset values: state=IDLE; muldiv_stall_e=0, md_done_e=0, md_busy=0, md_result_e=0. All internal registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If md_valid_e & !kill_e: latch funct3 and operands, assert muldiv_stall_e combinationally in the same cycle.
  - Next state: funct3[2]=0 -> MUL, =1 -> DIV.
- MUL:
  - Counter runs MUL_LAT cycles; stall=1.
  - Full 64-bit product from sign-extended operands:
    - MUL: low word.
    - MULH: signed x signed.
    - MULHSU: signed x unsigned.
    - MULHU: unsigned x unsigned.
    - The H variants return the high word.
  - Last cycle -> DONE.
- DIV:
  - Operate on magnitudes for signed ops; 32 cycles, one quotient bit per cycle, counter 0..31; stall=1.
  - After iteration 31: fix signs.
    - Quotient negated if signs differ.
    - Remainder takes the dividend's sign.
  - Then -> DONE.
- DONE:
  - muldiv_stall_e=0, md_done_e=1, md_result_e valid for exactly this cycle; next state IDLE.
  - An md_valid_e seen in this cycle is not re-accepted (it is the completing instruction). The next M-op is accepted in IDLE on the following cycle.
- Latency from acceptance:
  - MUL ops: done at cycle MUL_LAT+1 (default 3).
  - DIV/REM: done at cycle 33.
- Boundary results (RISC-V spec):
  - Divide by zero: DIV/DIVU give all-ones (0xFFFFFFFF); REM/REMU give the dividend.
  - Signed overflow (0x80000000 / -1): DIV gives 0x80000000, REM gives 0.
- kill_e in any non-IDLE state, or together with acceptance:
  - Next state IDLE, no md_done_e, stall drops the following cycle.
  - kill_e in DONE suppresses md_done_e in that cycle.
- reset mid-operation: IDLE next cycle, no md_done_e.
- md_result_e holds the last value when md_done_e=0; it is don't-care for consumers.

Optional Feature:
- Macro: MULDIV_DIV_EARLY_OUT_EN.
- Defined:
  - DIV/REM with divisor zero, or signed overflow, goes IDLE -> DONE directly with the spec result (done at cycle 1).
  - Also, when the unsigned dividend < divisor: quotient=0, remainder=dividend, done at cycle 1.
- Undefined: every DIV-class op takes the full 33 cycles; results are identical.

Decomposition:
- Package `muldiv_pkg`:
  - XLEN constant.
  - `md_op_e` enum of the 8 funct3 encodings.
  - `md_state_e` enum {IDLE, MUL, DIV, DONE}.
  - DIV_CNT_W = 5.
- Sub-module `div_core`:
  - Restoring-divide datapath: shift/subtract of the remainder/quotient registers, driven by `step`/`load` from the sequencer FSM.
  - Sign fix-up is done in the sequencer.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD): stall for cycles 0-2, done at cycle 3, result 0xFFFFFFEB. MULH same operands -> 0xFFFFFFFF. MULHU -> 0x00000006.
- DIV -20 / 3 -> quotient 0xFFFFFFFA (-6), done at cycle 33. REM -> 0xFFFFFFFE (-2). DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. With MULDIV_DIV_EARLY_OUT_EN these are done at cycle 1, otherwise at cycle 33.
- kill_e at DIV cycle 10: state IDLE next cycle, stall low, no md_done_e; a new MUL accepted the following cycle completes normally.
- Back-to-back: MUL then DIV with md_valid_e high in the DONE cycle: exactly one md_done_e per op, second op accepted the cycle after DONE, no duplicate acceptance.
- reset asserted at MUL cycle 1: all outputs 0 next cycle; a following op behaves as from power-up.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_CNT_W = 5;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } md_state_e;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> multiply/divide sequencer handshake.
interface muldiv_if;
   import muldiv_pkg::*;

   logic            md_valid_e;
   logic [2:0]      md_funct3_e;
   logic [XLEN-1:0] src_a_e;
   logic [XLEN-1:0] src_b_e;
   logic            kill_e;
   logic            muldiv_stall_e;
   logic [XLEN-1:0] md_result_e;
   logic            md_done_e;
   logic            md_busy;

   modport master (
      output md_valid_e, md_funct3_e, src_a_e, src_b_e, kill_e,
      input  muldiv_stall_e, md_result_e, md_done_e, md_busy
   );

   modport slave (
      input  md_valid_e, md_funct3_e, src_a_e, src_b_e, kill_e,
      output muldiv_stall_e, md_result_e, md_done_e, md_busy
   );

endinterface

// File: rtl/div_core.sv
// Unsigned restoring-divide datapath; one quotient bit per step, magnitudes only.
module div_core
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quo_step,
   output logic [XLEN-1:0] rem_step
);

   logic [XLEN-1:0] quo_q, rem_q, dvs_q;
   logic [XLEN:0]   trial;

   // Partial remainder stays below the divisor, so bit XLEN of the trial is the borrow.
   always_comb begin
      trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
      if (trial[XLEN]) begin
         rem_step = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
         quo_step = {quo_q[XLEN-2:0], 1'b0};
      end else begin
         rem_step = trial[XLEN-1:0];
         quo_step = {quo_q[XLEN-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         quo_q <= dividend;
         rem_q <= '0;
         dvs_q <= divisor;
      end else if (step) begin
         quo_q <= quo_step;
         rem_q <= rem_step;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execute-stage sequencer: fixed-latency multiply and 32-step restoring divide.
// Build option MULDIV_DIV_EARLY_OUT_EN: x/0, signed overflow and |a|<|b| divides finish in one cycle.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT   = 2,
   parameter int DIV_ITERS = 32
) (
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave md
);
   // state | meaning
   // IDLE  | waiting for an M-op; acceptance stalls E in the same cycle
   // MUL   | multiplier latency countdown
   // DIV   | one restoring-divide iteration per cycle
   // DONE  | result presented for one cycle, stall released

   localparam logic [DIV_CNT_W-1:0] MUL_LOAD = DIV_CNT_W'(MUL_LAT - 1);
   localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_ITERS - 1);

   md_state_e            state_q, state_nxt;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_nxt;
   md_op_e               op_q;
   logic [XLEN-1:0]      a_q, b_q, result_q, result_nxt;
   logic                 neg_quo_q, neg_rem_q, div_zero_q;

   logic                 accept, div_signed_in, load, step, stall, done;
   logic [XLEN-1:0]      a_mag, b_mag, quo_step, rem_step, quo_fix, rem_fix, div_sel, mul_sel;
   logic [2*XLEN-1:0]    mul_a, mul_b, prod;
   logic                 early_hit;
   logic [XLEN-1:0]      early_res;

   assign accept        = (state_q == IDLE) && md.md_valid_e && !md.kill_e;
   assign div_signed_in = !md.md_funct3_e[0];
   assign a_mag         = mag(md.src_a_e, div_signed_in);
   assign b_mag         = mag(md.src_b_e, div_signed_in);

   div_core u_div_core (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .step     (step),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo_step (quo_step),
      .rem_step (rem_step)
   );

`ifdef MULDIV_DIV_EARLY_OUT_EN
   logic div_ovf_in;

   always_comb begin
      div_ovf_in = div_signed_in && (md.src_a_e == {1'b1, {(XLEN-1){1'b0}}}) && (&md.src_b_e);
      early_hit  = 1'b1;
      early_res  = '0;
      if (md.src_b_e == '0)
         early_res = md.md_funct3_e[1] ? md.src_a_e : '1;
      else if (div_ovf_in)
         early_res = md.md_funct3_e[1] ? '0 : md.src_a_e;
      else if (a_mag < b_mag)
         early_res = md.md_funct3_e[1] ? md.src_a_e : '0;
      else
         early_hit = 1'b0;
   end
`else
   assign early_hit = 1'b0;
   assign early_res = '0;
`endif

   // Sign-extending to 2*XLEN lets one unsigned multiplier serve all four variants.
   always_comb begin
      mul_a   = {{XLEN{(op_q == OP_MULH || op_q == OP_MULHSU) && a_q[XLEN-1]}}, a_q};
      mul_b   = {{XLEN{(op_q == OP_MULH) && b_q[XLEN-1]}}, b_q};
      prod    = mul_a * mul_b;
      mul_sel = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      quo_fix = div_zero_q ? '1 : (neg_quo_q ? (~quo_step + XLEN'(1)) : quo_step);
      rem_fix = neg_rem_q ? (~rem_step + XLEN'(1)) : rem_step;
      div_sel = op_q[1] ? rem_fix : quo_fix;
   end

   always_comb begin
      state_nxt  = state_q;
      cnt_nxt    = cnt_q;
      result_nxt = result_q;
      load       = 1'b0;
      step       = 1'b0;
      stall      = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               stall = 1'b1;
               if (!md.md_funct3_e[2]) begin
                  state_nxt = MUL;
                  cnt_nxt   = MUL_LOAD;
               end else if (early_hit) begin
                  state_nxt  = DONE;
                  result_nxt = early_res;
               end else begin
                  state_nxt = DIV;
                  cnt_nxt   = DIV_LOAD;
                  load      = 1'b1;
               end
            end
         end
         MUL: begin
            stall = 1'b1;
            if (md.kill_e) begin
               state_nxt = IDLE;
            end else if (cnt_q == '0) begin
               state_nxt  = DONE;
               result_nxt = mul_sel;
            end else begin
               cnt_nxt = cnt_q - DIV_CNT_W'(1);
            end
         end
         DIV: begin
            stall = 1'b1;
            if (md.kill_e) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (cnt_q == '0) begin
                  state_nxt  = DONE;
                  result_nxt = div_sel;
               end else begin
                  cnt_nxt = cnt_q - DIV_CNT_W'(1);
               end
            end
         end
         DONE: begin
            done      = !md.kill_e;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= OP_MUL;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         result_q <= result_nxt;
         if (accept) begin
            op_q       <= md_op_e'(md.md_funct3_e);
            a_q        <= md.src_a_e;
            b_q        <= md.src_b_e;
            neg_quo_q  <= div_signed_in && (md.src_a_e[XLEN-1] ^ md.src_b_e[XLEN-1]);
            neg_rem_q  <= div_signed_in && md.src_a_e[XLEN-1];
            div_zero_q <= (md.src_b_e == '0);
         end
      end
   end

   assign md.muldiv_stall_e = stall;
   assign md.md_done_e      = done;
   assign md.md_result_e    = result_q;
   assign md.md_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M cases, kill/reset corners, random ops.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int MUL_LAT = 2;

   logic clk = 1'b0;
   logic reset;
   int   cyc    = 0;
   int   errs   = 0;
   int   checks = 0;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t sb[$];

   muldiv_if md();

   muldiv_sequencer #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sbv, ua, ub, p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = longint'({32'h0, a});
      ub  = longint'({32'h0, b});
      case (f3)
         3'd0: begin p = sa * sbv; return p[31:0]; end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * ub;  return p[63:32]; end
         3'd3: begin p = ua * ub;  return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sbv; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub;  return p[31:0]; end
         3'd6: begin if (b == 0) return a; p = sa % sbv; return p[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EARLY_OUT_EN
      logic        sg;
      logic [31:0] am, bm;
`endif
      if (!f3[2]) return MUL_LAT + 1;
`ifdef MULDIV_DIV_EARLY_OUT_EN
      sg = !f3[0];
      am = (sg && a[31]) ? -a : a;
      bm = (sg && b[31]) ? -b : b;
      if (b == 0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || am < bm) return 1;
`endif
      return 33;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (md.md_done_e) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", md.md_result_e, e.res);
            chk("latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   // Leaves valid asserted through the DONE cycle, as a stalled E stage would.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      md.md_valid_e  = 1'b1;
      md.md_funct3_e = f3;
      md.src_a_e     = a;
      md.src_b_e     = b;
      @(negedge clk);
      e.res = exp;
      e.due = cyc + lat_of(f3, a, b);
      sb.push_back(e);
      n = 0;
      while (md.md_done_e !== 1'b1 && n < 60) begin
         chk("stall_busy", {31'd0, md.muldiv_stall_e}, 32'd1);
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("done_timeout", 32'd0, 32'd1);
      else         chk("stall_done", {31'd0, md.muldiv_stall_e}, 32'd0);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      md.md_valid_e = 1'b0;
      md.kill_e     = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_stall"}, {31'd0, md.muldiv_stall_e}, 32'd0);
      chk({tag, "_done"},  {31'd0, md.md_done_e},      32'd0);
      chk({tag, "_busy"},  {31'd0, md.md_busy},        32'd0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;

      reset          = 1'b1;
      md.md_valid_e  = 1'b0;
      md.md_funct3_e = 3'd0;
      md.src_a_e     = '0;
      md.src_b_e     = '0;
      md.kill_e      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_result", md.md_result_e, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      do_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB); idle();
      do_op(OP_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF); idle();
      do_op(OP_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006); idle();
      do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF); idle();
      do_op(OP_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA); idle();
      do_op(OP_REM,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE); idle();
      do_op(OP_DIVU,   32'd100,       32'd7,         32'd14);        idle();
      do_op(OP_REMU,   32'd100,       32'd7,         32'd2);         idle();
      do_op(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF); idle();
      do_op(OP_REM,    32'd5,         32'd0,         32'd5);         idle();
      do_op(OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF); idle();
      do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); idle();
      do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000); idle();
      do_op(OP_DIVU,   32'd3,         32'd10,        32'd0);         idle();

      // kill together with acceptance
      @(posedge clk); #1;
      md.md_valid_e = 1'b1; md.md_funct3_e = OP_MUL; md.kill_e = 1'b1;
      md.src_a_e = 32'd9; md.src_b_e = 32'd9;
      idle();
      @(negedge clk);
      chk_quiet("kill_acc");

      // kill in the middle of a divide
      @(posedge clk); #1;
      md.md_valid_e = 1'b1; md.md_funct3_e = OP_DIV;
      md.src_a_e = 32'd1000; md.src_b_e = 32'd7;
      repeat (10) @(posedge clk);
      #1 md.kill_e = 1'b1;
      idle();
      @(negedge clk);
      chk_quiet("kill_div");
      do_op(OP_MUL, 32'd12, 32'd11, 32'd132); idle();

      // kill in DONE suppresses the completion
      @(posedge clk); #1;
      md.md_valid_e = 1'b1; md.md_funct3_e = OP_MUL;
      md.src_a_e = 32'd3; md.src_b_e = 32'd4;
      repeat (MUL_LAT + 1) @(posedge clk);
      #1 md.kill_e = 1'b1;
      @(negedge clk);
      chk("kill_done_done", {31'd0, md.md_done_e}, 32'd0);
      idle();
      @(negedge clk);
      chk_quiet("kill_done_after");

      // reset during MUL
      @(posedge clk); #1;
      md.md_valid_e = 1'b1; md.md_funct3_e = OP_MUL;
      md.src_a_e = 32'd7; md.src_b_e = 32'd3;
      @(posedge clk); #1;
      reset = 1'b1; md.md_valid_e = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk_quiet("rst_mid");
      chk("rst_mid_result", md.md_result_e, 32'h0);
      do_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB); idle();

      // back-to-back with valid held through DONE
      do_op(OP_MUL,  32'd6,   32'd7, 32'd42);
      do_op(OP_DIVU, 32'd100, 32'd9, 32'd11);
      do_op(OP_REMU, 32'd100, 32'd9, 32'd1);
      idle();

      for (int i = 0; i < 10; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         do_op(f3, a, b, ref_md(f3, a, b));
         idle();
      end

      repeat (40) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
